// File: rtl/adc_scan_scheduler_if.sv
// adc_scan_scheduler_if: host control, ADC handshake and result read port of the scan scheduler.
interface adc_scan_scheduler_if #(
  parameter int NUM_CH = 8,
  parameter int RES_W = 12
);
  logic start;
  logic continuous;
  logic stop;
  logic [NUM_CH-1:0] ch_mask;
  logic adc_valid;
  logic [RES_W-1:0] adc_result;
  logic [$clog2(NUM_CH)-1:0] chan;
  logic busy;
  logic done;
  logic [NUM_CH-1:0] ch_valid;
  logic [$clog2(NUM_CH)-1:0] rd_addr;
  logic [RES_W-1:0] rd_data;
  logic [7:0] pass_count;
  modport slave (
    input start, continuous, stop, ch_mask, adc_valid, adc_result, rd_addr,
    output chan, busy, done, ch_valid, rd_data, pass_count
  );
  modport master (
    output start, continuous, stop, ch_mask, adc_valid, adc_result, rd_addr,
    input chan, busy, done, ch_valid, rd_data, pass_count
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: LTC2308 multi-channel scan sequencer with per-channel result registers.
// Define ADC_SCAN_AVG4_EN to hold each channel for four frames and store the 4-sample average.
module adc_scan_scheduler #(
  parameter int NUM_CH = 8,
  parameter int RES_W = 12
) (
  input logic clk,
  input logic reset,
  adc_scan_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRIME, SCAN, DRAIN} state_t;
  state_t state, state_d;
  logic [NUM_CH-1:0] mask_q, chv;
  logic [RES_W-1:0] res [NUM_CH];
  logic [RES_W-1:0] wr_val;
  logic [2:0] ch, pend, lo, hi, nxt;
  logic [7:0] pc;
  logic cont_q, stop_q, done_q;
  logic take, issue, drain_v, acc_en, hold, wr, wr_now, last_issue;
  always_comb begin
    lo = '0;
    hi = '0;
    nxt = ch;
    for (int i = NUM_CH - 1; i >= 0; i--) if (bus.ch_mask[i]) lo = 3'(i);
    for (int i = 0; i < NUM_CH; i++) if (mask_q[i]) hi = 3'(i);
    for (int i = NUM_CH - 1; i >= 1; i--) if (mask_q[3'(ch + 3'(i))]) nxt = 3'(ch + 3'(i));
    take = state == IDLE && bus.start && bus.ch_mask != '0;
    issue = bus.adc_valid && (state == PRIME || state == SCAN);
    drain_v = bus.adc_valid && state == DRAIN;
    acc_en = bus.adc_valid && (state == SCAN || state == DRAIN);
    hold = last_issue && ch == hi && (!cont_q || stop_q || bus.stop);
    wr = acc_en && wr_now;
    state_d = take ? PRIME : issue ? (hold ? DRAIN : SCAN) : drain_v ? IDLE : state;
  end
`ifdef ADC_SCAN_AVG4_EN
  logic [1:0] icnt;
  logic [RES_W+1:0] acc, sum;
  assign sum = acc + (RES_W + 2)'(bus.adc_result);
  assign last_issue = icnt == 2'd3;
  assign wr_now = icnt == 2'd0;
  assign wr_val = sum[RES_W+1:2];
  // Results lag issues by one frame, so a wrapped issue count marks the fourth sample.
  always_ff @(posedge clk)
    if (reset || take) begin
      icnt <= '0;
      acc <= '0;
    end else begin
      if (issue) icnt <= icnt + 2'd1;
      if (acc_en) acc <= wr_now ? '0 : sum;
    end
`else
  assign last_issue = 1'b1;
  assign wr_now = 1'b1;
  assign wr_val = bus.adc_result;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk)
    if (reset) begin
      ch <= '0;
      pend <= '0;
      mask_q <= '0;
      cont_q <= 1'b0;
      stop_q <= 1'b0;
      done_q <= 1'b0;
      chv <= '0;
      pc <= '0;
      for (int i = 0; i < NUM_CH; i++) res[i] <= '0;
    end else begin
      done_q <= (state == IDLE && bus.start && bus.ch_mask == '0) || drain_v;
      if (take) begin
        mask_q <= bus.ch_mask;
        cont_q <= bus.continuous;
        stop_q <= 1'b0;
        chv <= '0;
        ch <= lo;
      end else if (state != IDLE && bus.stop) stop_q <= 1'b1;
      if (issue || drain_v) pend <= ch;
      if (issue && last_issue && !hold) ch <= nxt;
      if (wr) begin
        res[pend] <= wr_val;
        chv[pend] <= 1'b1;
        if (pend == hi) pc <= pc + 8'd1;
      end
    end
  assign bus.chan = ch;
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  assign bus.ch_valid = chv;
  assign bus.rd_data = res[bus.rd_addr];
  assign bus.pass_count = pc;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler: randomized scans against a pass-level model, checked by a done/valid monitor.
module tb_adc_scan_scheduler;
`ifdef ADC_SCAN_AVG4_EN
  localparam int K = 4;
`else
  localparam int K = 1;
`endif
  typedef struct packed {
    logic [7:0] chv;
    logic [7:0] pc;
    logic [7:0][11:0] regs;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  adc_scan_scheduler_if bus ();
  adc_scan_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
  always #10 clk = ~clk;
  int n_pass = 0;
  int n_total = 0;
  int chan_q[$];
  rec_t done_q[$];
  logic [7:0][11:0] m_reg = '0;
  logic [7:0] m_chv = '0;
  logic [7:0] m_pc = '0;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_state;
    chk("rst_chan", bus.chan, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ch_valid", bus.ch_valid, 0);
    chk("rst_pass_count", bus.pass_count, 0);
  endtask
  task automatic do_valid(input int exp_ch, input logic [11:0] d);
    bus.adc_valid = 1'b1;
    bus.adc_result = d;
    chan_q.push_back(exp_ch);
    tick;
    bus.adc_valid = 1'b0;
    repeat ($urandom_range(0, 3)) tick;
  endtask
  // One scan: the model derives the channel order, pass count and averaged writes from the mask.
  task automatic run_scan(input logic [7:0] mask, input bit cont, input int passes, input int abort_at,
                          input bit poke, input bit same_valid);
    int ord[$];
    logic [11:0] d[$];
    int n, v, p, sum;
    rec_t r;
    for (int i = 0; i < 8; i++) if (mask[i]) ord.push_back(i);
    n = ord.size();
    p = cont ? passes : 1;
    v = p * K * n + 1;
    bus.start = 1'b1;
    bus.ch_mask = mask;
    bus.continuous = cont;
    bus.adc_valid = same_valid;
    bus.adc_result = 12'($urandom);
    if (same_valid) chan_q.push_back(-1);
    if (n == 0) begin
      r.chv = m_chv;
      r.pc = m_pc;
      r.regs = m_reg;
      done_q.push_back(r);
    end
    tick;
    bus.start = 1'b0;
    bus.adc_valid = 1'b0;
    if (n == 0) begin
      repeat (3) tick;
      return;
    end
    d.push_back(12'd0);
    for (int i = 1; i <= v; i++) d.push_back(12'($urandom));
    r.regs = m_reg;
    r.chv = '0;
    r.pc = m_pc + 8'(p);
    for (int g = 0; g < p * n; g++) begin
      sum = 0;
      for (int j = 1; j <= K; j++) sum += int'(d[g * K + 1 + j]);
      r.regs[ord[g % n]] = 12'(sum / K);
      r.chv[ord[g % n]] = 1'b1;
    end
    for (int i = 1; i <= v; i++) begin
      if (cont && i == (p - 1) * K * n + 1) begin
        bus.stop = 1'b1;
        tick;
        bus.stop = 1'b0;
      end
      if (poke && i == 2) begin
        bus.start = 1'b1;
        bus.ch_mask = ~mask;
        tick;
        bus.start = 1'b0;
      end
      if (i == abort_at) begin
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_reg = '0;
        m_chv = '0;
        m_pc = '0;
        check_reset_state();
        return;
      end
      if (i == v) done_q.push_back(r);
      do_valid(i <= p * K * n ? ord[((i - 1) / K) % n] : ord[n - 1], d[i]);
    end
    m_reg = r.regs;
    m_chv = r.chv;
    m_pc = r.pc;
    for (int t = 0; t < 50 && bus.busy; t++) tick;
    chk("scan_idle", bus.busy, 0);
    tick;
  endtask
  initial begin
    bus.rd_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.adc_valid) begin
        chk("chan_expected", int'(chan_q.size() != 0), 1);
        if (chan_q.size() != 0) begin
          int e;
          e = chan_q.pop_front();
          if (e >= 0) chk("chan", bus.chan, e);
        end
      end
      if (bus.done) begin
        chk("done_expected", int'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          rec_t r;
          r = done_q.pop_front();
          chk("done_busy", bus.busy, 0);
          chk("ch_valid", bus.ch_valid, r.chv);
          chk("pass_count", bus.pass_count, r.pc);
          for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            chk("rd_data", bus.rd_data, r.regs[a]);
          end
        end
      end
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.stop = 1'b0;
    bus.ch_mask = '0;
    bus.adc_valid = 1'b0;
    bus.adc_result = '0;
    repeat (3) tick;
    reset = 1'b0;
    check_reset_state();
    run_scan(8'h05, 1'b0, 1, 0, 1'b0, 1'b0);
    run_scan(8'h00, 1'b0, 1, 0, 1'b0, 1'b0);
    run_scan(8'h80, 1'b1, 5, 0, 1'b0, 1'b0);
    do_valid(-1, 12'h3c3);
    bus.stop = 1'b1;
    tick;
    bus.stop = 1'b0;
    run_scan(8'h21, 1'b0, 1, 0, 1'b0, 1'b1);
    run_scan(8'h12, 1'b1, 2, 0, 1'b1, 1'b0);
    run_scan(8'hFF, 1'b0, 1, 5, 1'b0, 1'b0);
    run_scan(8'h00, 1'b0, 1, 0, 1'b0, 1'b0);
    for (int s = 0; s < 14; s++)
      run_scan($urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(1, 3), 0, 1'($urandom_range(0, 1)) && s[0], 1'($urandom_range(0, 1)));
    repeat (5) tick;
    chk("chan_q_empty", chan_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
